// File: rtl/record_cache.sv
`default_nettype none
// ============================================================================
// Module   : record_cache
// Brief    : Loads a RAM-resident record table into a local array and serves
//            lookups by index (one cycle) or by key (linear scan).
// Revision : 1.0 - initial release
// ============================================================================
module record_cache #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 64,
  parameter int KEY_W  = 10,
  parameter int PERIOD = 1_000_000,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              refresh_req,
  output logic              ram_rd_req,
  output logic [IDX_W-1:0]  ram_rd_addr,
  input  logic              ram_rd_ack,
  input  logic              ram_rd_hit,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic              lk_mode,
  input  logic [IDX_W-1:0]  lk_index,
  input  logic [KEY_W-1:0]  lk_key,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [IDX_W-1:0]  resp_index,
  output logic [DATA_W-1:0] resp_data,
  output logic [IDX_W:0]    count,
  output logic              refreshing
);

  localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RD_REQ = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   C_CNT_FULL = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   C_CNT_ONE  = (IDX_W + 1)'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_alive;
  logic [TMR_W-1:0]  r_timer;
  logic              r_pending;
  logic [IDX_W-1:0]  r_load_idx;
  logic [IDX_W:0]    r_count;
  logic [IDX_W-1:0]  r_scan_idx;
  logic [KEY_W-1:0]  r_key;
  logic              r_resp_valid;
  logic              r_resp_hit;
  logic [IDX_W-1:0]  r_resp_index;
  logic [DATA_W-1:0] r_resp_data;
  logic [DATA_W-1:0] r_entry [DEPTH];

  logic              w_idle;
  logic              w_tick;
  logic              w_lk_ready;
  logic              w_accept;
  logic              w_ref_start;
  logic              w_rd_ack;
  logic              w_rd_last;
  logic              w_rd_done;
  logic              w_scan;
  logic [DATA_W-1:0] w_scan_rec;
  logic [KEY_W-1:0]  w_scan_key;
  logic              w_scan_match;
  logic              w_scan_last;
  logic              w_scan_miss;
  logic              w_lk_hit;
  logic              w_empty;

  assign w_idle       = (r_state == S_IDLE);
  assign w_tick       = en & (r_timer == C_TMR_LAST);
  // r_alive keeps lk_ready low during reset and for the edge that releases it
  assign w_lk_ready   = en & r_alive & w_idle & ~r_pending;
  assign w_accept     = lk_valid & w_lk_ready;
  assign w_ref_start  = en & w_idle & r_pending;
  assign w_rd_ack     = en & (r_state == S_RD_REQ) & ram_rd_ack;
  assign w_rd_last    = ~ram_rd_hit | (r_load_idx == C_IDX_LAST);
  assign w_rd_done    = w_rd_ack & w_rd_last;
  assign w_scan       = en & (r_state == S_SCAN);
  assign w_scan_rec   = r_entry[r_scan_idx];
  assign w_scan_key   = w_scan_rec[DATA_W-1 -: KEY_W];
  assign w_scan_match = w_scan & (w_scan_key == r_key);
  assign w_scan_last  = (({1'b0, r_scan_idx} + C_CNT_ONE) == r_count);
  assign w_scan_miss  = w_scan & w_scan_last & ~w_scan_match;
  assign w_lk_hit     = ({1'b0, lk_index} < r_count);
  assign w_empty      = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            w_state_nxt = S_RD_REQ;
          end else if (w_accept) begin
            w_state_nxt = (lk_mode & ~w_empty) ? S_SCAN : S_RESP;
          end
        end
        S_RD_REQ: if (w_rd_done) w_state_nxt = S_IDLE;
        S_SCAN:   if (w_scan_match | w_scan_last) w_state_nxt = S_RESP;
        S_RESP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_rd_req = (r_state == S_RD_REQ);
    refreshing = (r_state == S_RD_REQ);
    lk_ready   = w_lk_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive    <= 1'b0;
      r_timer    <= '0;
      r_pending  <= 1'b0;
      r_load_idx <= '0;
      r_count    <= '0;
    end else begin
      r_alive <= 1'b1;
      if (!en) begin
        r_timer    <= '0;
        r_pending  <= 1'b0;
        r_load_idx <= '0;
        r_count    <= '0;
      end else begin
        r_timer   <= w_tick ? '0 : r_timer + C_TMR_ONE;
        // a trigger arriving mid-refresh or mid-lookup is only remembered
        r_pending <= w_tick | refresh_req | (r_pending & ~w_ref_start);
        if (w_ref_start) begin
          r_load_idx <= '0;
        end else if (w_rd_ack & ~w_rd_last) begin
          r_load_idx <= r_load_idx + C_IDX_ONE;
        end
        if (w_rd_ack & ~ram_rd_hit) begin
          r_count <= {1'b0, r_load_idx};
        end else if (w_rd_done) begin
          r_count <= C_CNT_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_ack & ram_rd_hit) begin
      r_entry[r_load_idx] <= ram_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= '0;
      r_scan_idx   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_index <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_key      <= lk_key;
        r_scan_idx <= '0;
      end else if (w_scan) begin
        r_scan_idx <= r_scan_idx + C_IDX_ONE;
      end
      if (w_accept & ~lk_mode) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= w_lk_hit;
        r_resp_index <= lk_index;
        r_resp_data  <= w_lk_hit ? r_entry[lk_index] : '0;
      end else if ((w_accept & lk_mode & w_empty) | w_scan_miss) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= 1'b0;
        r_resp_index <= '0;
        r_resp_data  <= '0;
      end else if (w_scan_match) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= 1'b1;
        r_resp_index <= r_scan_idx;
        r_resp_data  <= w_scan_rec;
      end
    end
  end

  assign ram_rd_addr = r_load_idx;
  assign count       = r_count;
  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_index  = r_resp_index;
  assign resp_data   = r_resp_data;

endmodule
`default_nettype wire
